calc_exec_ctrl: RTL and testbench
=================================

// Module: calc_exec_ctrl
// PURPOSE
//  Execution sequencer between the operand/operator capture FSM and the 7-seg result path.
//  Accepts {operand1, operand2, md_operator} on a start pulse. Schedules one shared iterative
//  unit: a 4-step shift-add multiplier plus a 4-step restoring divider. Returns an 8-bit result
//  with done/error/overflow flags.
//  Covers basic mode (add, sub, mul, div) and scientific mode (square, power, factorial, mod).
// PARAMETERS
//  FACT_LIMIT  5      largest n computed for n!; n > FACT_LIMIT saturates (5! = 120 fits in 8 bits)
//  SAT_VALUE   8'hFF  result driven on overflow
// PORTS
//  clock        in   1  system clock; all state changes on rising edge
//  reset        in   1  synchronous, active-low reset
//  start        in   1  request; sampled only while idle (busy=0)
//  operand1     in   4  a, unsigned
//  operand2     in   4  b, unsigned
//  md_operator  in   3  {mode, op}: 000 add, 001 sub, 010 mul, 011 div, 100 a*a, 101 a^b, 110 a!, 111 a mod b
//  busy         out  1  high in every non-IDLE state
//  done         out  1  one-cycle pulse; result/flags valid from this cycle on
//  result       out  8  registered result; held until the next done
//  error        out  1  divide/mod by zero; held with result
//  overflow     out  1  power/factorial saturated; held with result
// BEHAVIOUR
//  Reset (reset=0 at an edge):
//   - state -> IDLE.
//   - busy, done, result, error, overflow all forced to 0.
//   - Applies mid-operation: no done for the aborted op.
//  Start capture (edge S):
//   - In IDLE with start=1: latch a, b, op into internal registers.
//   - Later input changes are ignored until the next capture.
//   - start while busy=1 is ignored, not queued.
//  States:
//   - IDLE -> ADDSUB | MUL | DIV | FINISH_IMM.
//   - MUL: 4 steps; loops per pass for power/factorial.
//   - DIV: 4 steps.
//   - FINISH: writes result/flags, pulses done, returns to IDLE.
//  done rises at the same edge that state returns to IDLE (busy falls).
//   - A new start in the done cycle is accepted (back-to-back).
//  Latency, counted as edges after S at which done rises:
//   - add/sub: S+1.
//   - mul/square/div/mod: S+4.
//   - power: S+4*b; b=0 gives result 1 at S+1.
//   - factorial: S+4*(a-1); a<=1 gives result 1 at S+1.
//  Arithmetic:
//   - add: {3'b0, a+b}, 5-bit sum.
//   - sub: 8-bit two's complement of a-b, e.g. 3-5 = 8'hFE.
//   - mul/square: 8-bit product, never overflows (max 225).
//   - div: {remainder[3:0], quotient[3:0]}. mod: {4'b0, remainder}.
//  Multiplier pass:
//   - 8-bit accumulator x 4-bit multiplier -> 12-bit product, one multiplier bit per cycle, LSB first.
//   - Power: acc=1, multiply by a, b passes.
//   - Factorial: acc=1, multiply by k=2..a.
//  Overflow:
//   - Power/factorial: after each pass, product>255 -> result=SAT_VALUE, overflow=1, done at that edge.
//     Remaining passes are skipped.
//   - Factorial with a>FACT_LIMIT: SAT_VALUE, overflow=1 at S+1 (early out, no passes).
//  Zero divisor:
//   - div/mod with b=0 -> result 8'h00, error=1, done at S+1; divider not run.
//  Flag clearing: error and overflow both clear at the next done that does not set them.
// TESTING
//  - 9+7, op 000 -> done at S+1, result 8'h10, error=0, overflow=0; 3-5, op 001 -> 8'hFE at S+1.
//  - 15*15, op 010 -> done S+4, 8'hE1; 13/4, op 011 -> S+4, 8'h13; 14 mod 5, op 111 -> 8'h04.
//  - 7/0, op 011 -> done S+1, result 8'h00, error=1; then 2+2 -> 8'h04, error=0.
//  - 3^5, op 101 -> done S+20, 8'hF3; 4^4 -> done S+16, 8'hFF, overflow=1; 9^0 -> S+1, 8'h01.
//  - 5!, op 110 -> done S+16, 8'h78; 6! -> S+1, 8'hFF, overflow=1; 0! -> S+1, 8'h01.
//  - Busy and reset cases:
//     start mul, pulse start again at S+2 -> ignored, single done at S+4;
//     start mul, reset=0 at S+2 -> busy=0, all outputs 0, no done.

Source files
------------

// File: rtl/calc_exec_ctrl_if.sv
// Request/result bundle between the capture FSM (master) and the execution sequencer (slave).
interface calc_exec_ctrl_if;
   logic       start;
   logic [3:0] operand1;
   logic [3:0] operand2;
   logic [2:0] md_operator;
   logic       busy;
   logic       done;
   logic [7:0] result;
   logic       error;
   logic       overflow;

   modport master (
      output start, operand1, operand2, md_operator,
      input  busy, done, result, error, overflow
   );

   modport slave (
      input  start, operand1, operand2, md_operator,
      output busy, done, result, error, overflow
   );
endinterface

// File: rtl/calc_exec_ctrl.sv
// Execution sequencer: one shared shift-add multiplier / restoring divider, 4 steps per pass,
// producing an 8-bit result with done/error/overflow flags.
module calc_exec_ctrl #(
   parameter int         FACT_LIMIT = 5,
   parameter logic [7:0] SAT_VALUE  = 8'hFF
) (
   input logic           clock,
   input logic           reset,
   calc_exec_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, FINISH, MUL, DIV} state_t;

   state_t      state_q, state_d;
   logic [3:0]  a_q, a_d, b_q, b_d;
   logic [2:0]  op_q, op_d;
   logic [1:0]  step_q, step_d;
   logic [7:0]  acc_q, acc_d;
   logic [3:0]  mplier_q, mplier_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [11:0] prod_q, prod_d;
   logic [3:0]  rem_q, rem_d, dvd_q, dvd_d;
   logic        done_q, done_d, error_q, error_d, overflow_q, overflow_d;
   logic [7:0]  result_q, result_d;
   logic [11:0] partial;
   logic [4:0]  rshift;
   logic        qbit;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q    <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         step_q     <= '0;
         acc_q      <= '0;
         mplier_q   <= '0;
         cnt_q      <= '0;
         prod_q     <= '0;
         rem_q      <= '0;
         dvd_q      <= '0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         overflow_q <= 1'b0;
         result_q   <= '0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         op_q       <= op_d;
         step_q     <= step_d;
         acc_q      <= acc_d;
         mplier_q   <= mplier_d;
         cnt_q      <= cnt_d;
         prod_q     <= prod_d;
         rem_q      <= rem_d;
         dvd_q      <= dvd_d;
         done_q     <= done_d;
         error_q    <= error_d;
         overflow_q <= overflow_d;
         result_q   <= result_d;
      end
   end

   // Datapath for the current step: one multiplier bit or one quotient bit, MSB of dividend first.
   always_comb begin
      partial = prod_q + (mplier_q[step_q] ? ({4'b0, acc_q} << step_q) : 12'd0);
      rshift  = {rem_q, dvd_q[3]};
      qbit    = (rshift >= {1'b0, b_q});
   end

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      op_d       = op_q;
      step_d     = step_q;
      acc_d      = acc_q;
      mplier_d   = mplier_q;
      cnt_d      = cnt_q;
      prod_d     = prod_q;
      rem_d      = rem_q;
      dvd_d      = dvd_q;
      done_d     = 1'b0;
      error_d    = error_q;
      overflow_d = overflow_q;
      result_d   = result_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_d      = bus.operand1;
               b_d      = bus.operand2;
               op_d     = bus.md_operator;
               step_d   = '0;
               prod_d   = '0;
               rem_d    = '0;
               dvd_d    = bus.operand1;
               acc_d    = 8'd1;
               mplier_d = bus.operand1;
               cnt_d    = 4'd1;
               state_d  = FINISH;
               case (bus.md_operator)
                  3'b010: begin
                     acc_d    = {4'b0, bus.operand1};
                     mplier_d = bus.operand2;
                     state_d  = MUL;
                  end
                  3'b100: begin
                     acc_d    = {4'b0, bus.operand1};
                     state_d  = MUL;
                  end
                  3'b101: begin
                     cnt_d = bus.operand2;
                     if (bus.operand2 != 4'd0) state_d = MUL;
                  end
                  3'b110: begin
                     mplier_d = 4'd2;
                     cnt_d    = bus.operand1 - 4'd1;
                     if (bus.operand1 > 4'd1 && bus.operand1 <= 4'(FACT_LIMIT)) state_d = MUL;
                  end
                  3'b011, 3'b111: begin
                     if (bus.operand2 != 4'd0) state_d = DIV;
                  end
                  default: state_d = FINISH;
               endcase
            end
         end

         // Single-cycle results: add/sub and every early-out case.
         FINISH: begin
            done_d     = 1'b1;
            state_d    = IDLE;
            error_d    = 1'b0;
            overflow_d = 1'b0;
            result_d   = 8'd1;
            case (op_q)
               3'b000: result_d = {3'b0, {1'b0, a_q} + {1'b0, b_q}};
               3'b001: result_d = {4'b0, a_q} - {4'b0, b_q};
               3'b011, 3'b111: begin
                  result_d = 8'h00;
                  error_d  = 1'b1;
               end
               3'b110: begin
                  if (a_q > 4'(FACT_LIMIT)) begin
                     result_d   = SAT_VALUE;
                     overflow_d = 1'b1;
                  end
               end
               default: result_d = 8'd1;
            endcase
         end

         MUL: begin
            step_d = step_q + 2'd1;
            prod_d = partial;
            if (step_q == 2'd3) begin
               if (partial > 12'd255 || cnt_q == 4'd1) begin
                  done_d     = 1'b1;
                  state_d    = IDLE;
                  error_d    = 1'b0;
                  overflow_d = (partial > 12'd255);
                  result_d   = (partial > 12'd255) ? SAT_VALUE : partial[7:0];
               end else begin
                  cnt_d  = cnt_q - 4'd1;
                  acc_d  = partial[7:0];
                  prod_d = '0;
                  if (op_q == 3'b110) mplier_d = mplier_q + 4'd1;
               end
            end
         end

         DIV: begin
            step_d = step_q + 2'd1;
            rem_d  = qbit ? 4'(rshift - {1'b0, b_q}) : rshift[3:0];
            dvd_d  = {dvd_q[2:0], qbit};
            if (step_q == 2'd3) begin
               done_d     = 1'b1;
               state_d    = IDLE;
               error_d    = 1'b0;
               overflow_d = 1'b0;
               result_d   = (op_q == 3'b011) ? {rem_d, dvd_d} : {4'b0, rem_d};
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign bus.busy     = (state_q != IDLE);
   assign bus.done     = done_q;
   assign bus.result   = result_q;
   assign bus.error    = error_q;
   assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_calc_exec_ctrl.sv
// Directed bench for calc_exec_ctrl: hand-computed results, latencies, busy and reset behaviour.
module tb_calc_exec_ctrl;
   logic clock = 1'b0;
   logic reset = 1'b0;
   int   compared = 0;
   int   mismatched = 0;

   calc_exec_ctrl_if bus ();

   calc_exec_ctrl #(.FACT_LIMIT(5), .SAT_VALUE(8'hFF)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one request, scramble inputs after capture, and measure edges until done.
   task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] op, input int exp_lat, input logic [7:0] exp_res,
                         input logic exp_err, input logic exp_ovf);
      int lat;
      bit seen;
      @(negedge clock);
      bus.start = 1'b1;
      bus.operand1 = a;
      bus.operand2 = b;
      bus.md_operator = op;
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      bus.operand1 = ~a;
      bus.operand2 = ~b;
      bus.md_operator = ~op;
      lat = 0;
      seen = 0;
      while (!seen && lat < 100) begin
         @(posedge clock);
         #1;
         lat++;
         if (bus.done === 1'b1) seen = 1;
      end
      check({tag, " latency"}, lat, exp_lat);
      check({tag, " result"}, bus.result, exp_res);
      check({tag, " error"}, bus.error, exp_err);
      check({tag, " overflow"}, bus.overflow, exp_ovf);
      check({tag, " busy_at_done"}, bus.busy, 1'b0);
      @(posedge clock);
      #1;
      check({tag, " done_pulse"}, bus.done, 1'b0);
      $display("op %s a=%0d b=%0d op=%0d latency=%0d result=%02h err=%0b ovf=%0b",
               tag, a, b, op, lat, bus.result, bus.error, bus.overflow);
   endtask

   initial begin
      int ndone;
      int done_edge;
      bus.start = 1'b0;
      bus.operand1 = '0;
      bus.operand2 = '0;
      bus.md_operator = '0;
      repeat (2) @(posedge clock);
      #1;
      check("reset busy", bus.busy, 1'b0);
      check("reset done", bus.done, 1'b0);
      check("reset result", bus.result, 8'h00);
      check("reset error", bus.error, 1'b0);
      check("reset overflow", bus.overflow, 1'b0);
      $display("reset busy=%0b done=%0b result=%02h", bus.busy, bus.done, bus.result);
      @(negedge clock);
      reset = 1'b1;

      run_op("add", 4'd9, 4'd7, 3'b000, 1, 8'h10, 1'b0, 1'b0);
      run_op("sub", 4'd3, 4'd5, 3'b001, 1, 8'hFE, 1'b0, 1'b0);
      run_op("mul", 4'd15, 4'd15, 3'b010, 4, 8'hE1, 1'b0, 1'b0);
      run_op("div", 4'd13, 4'd4, 3'b011, 4, 8'h13, 1'b0, 1'b0);
      run_op("mod", 4'd14, 4'd5, 3'b111, 4, 8'h04, 1'b0, 1'b0);
      run_op("div0", 4'd7, 4'd0, 3'b011, 1, 8'h00, 1'b1, 1'b0);
      run_op("add_clr", 4'd2, 4'd2, 3'b000, 1, 8'h04, 1'b0, 1'b0);
      run_op("square", 4'd12, 4'd0, 3'b100, 4, 8'h90, 1'b0, 1'b0);
      run_op("pow3_5", 4'd3, 4'd5, 3'b101, 20, 8'hF3, 1'b0, 1'b0);
      run_op("pow4_4", 4'd4, 4'd4, 3'b101, 16, 8'hFF, 1'b0, 1'b1);
      run_op("pow9_0", 4'd9, 4'd0, 3'b101, 1, 8'h01, 1'b0, 1'b0);
      run_op("fact5", 4'd5, 4'd0, 3'b110, 16, 8'h78, 1'b0, 1'b0);
      run_op("fact6", 4'd6, 4'd0, 3'b110, 1, 8'hFF, 1'b0, 1'b1);
      run_op("fact0", 4'd0, 4'd0, 3'b110, 1, 8'h01, 1'b0, 1'b0);
      run_op("mod0", 4'd9, 4'd0, 3'b111, 1, 8'h00, 1'b1, 1'b0);
      run_op("fact3", 4'd3, 4'd0, 3'b110, 8, 8'h06, 1'b0, 1'b0);

      // Second start while busy must be dropped.
      @(negedge clock);
      bus.start = 1'b1;
      bus.operand1 = 4'd15;
      bus.operand2 = 4'd15;
      bus.md_operator = 3'b010;
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      check("busy_after_start", bus.busy, 1'b1);
      @(posedge clock);
      @(negedge clock);
      bus.start = 1'b1;
      bus.operand1 = 4'd1;
      bus.operand2 = 4'd1;
      bus.md_operator = 3'b000;
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      ndone = 0;
      done_edge = 0;
      for (int k = 3; k <= 12; k++) begin
         @(posedge clock);
         #1;
         if (bus.done === 1'b1) begin
            ndone++;
            if (done_edge == 0) begin
               done_edge = k;
               check("ignored_start result", bus.result, 8'hE1);
            end
         end
      end
      check("ignored_start done_count", ndone, 1);
      check("ignored_start done_edge", done_edge, 4);
      $display("busy_ignore dones=%0d edge=S+%0d result=%02h", ndone, done_edge, bus.result);

      // Reset in the middle of a multiply aborts it silently.
      @(negedge clock);
      bus.start = 1'b1;
      bus.operand1 = 4'd3;
      bus.operand2 = 4'd3;
      bus.md_operator = 3'b010;
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;
      check("abort busy", bus.busy, 1'b0);
      check("abort done", bus.done, 1'b0);
      check("abort result", bus.result, 8'h00);
      check("abort error", bus.error, 1'b0);
      check("abort overflow", bus.overflow, 1'b0);
      @(negedge clock);
      reset = 1'b1;
      ndone = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clock);
         #1;
         if (bus.done === 1'b1) ndone++;
      end
      check("abort no_done", ndone, 0);
      $display("abort busy=%0b result=%02h dones_after=%0d", bus.busy, bus.result, ndone);

      run_op("post_abort_add", 4'd15, 4'd15, 3'b000, 1, 8'h1E, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
